// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller (package mips_pkg):
// state encodings, opcode/funct constants and PC source selects.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Branches and jumps resolve in EXEC and return straight to FETCH.
    function automatic logic is_ctrl_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-decode inputs and datapath control outputs of multicycle_ctrl.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_wr;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [5:0] alu_sel;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       jal_link;
    logic [2:0] state;
    logic       mem_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, alu_sel, alu_src,
               reg_dst, mem_to_reg, pc_src, jal_link, state, mem_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, alu_sel, alu_src,
               reg_dst, mem_to_reg, pc_src, jal_link, state, mem_err
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts hold cycles of a pending access and forces
// completion at WAIT_MAX, latching a sticky error when it had to.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_ready,
    output logic o_done,
    output logic o_err
);
    localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_timeout;

    assign w_timeout = (32'(r_cnt) == WAIT_MAX);
    assign o_done    = i_ready | w_timeout;
    assign o_err     = r_err;

    // A ready arriving in the timeout cycle still counts as a clean access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_req) begin
            if (o_done) begin
                r_cnt <= '0;
                if (w_timeout && !i_ready) r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: registered state, combinational strobes.
// Define MULTICYCLE_CTRL_MEMWAIT_EN to make FETCH/MEM wait on mem_ready.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    state_t r_state;
    logic   r_rst_hold;
    logic   w_active;
    logic   w_mem_req;
    logic   w_mem_done;
    logic   w_mem_err;
    logic   w_rtype;
    logic   w_jr;
    logic   w_lw;

    // One quiet cycle after reset keeps every output low before fetching.
    assign w_active  = !rst && !r_rst_hold;
    assign w_rtype   = (bus.opcode == OP_RTYPE);
    assign w_jr      = w_rtype && (bus.funct == FN_JR);
    assign w_lw      = (bus.opcode == OP_LW);
    assign w_mem_req = w_active && ((r_state == S_FETCH) || (r_state == S_MEM));

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_mem_req),
        .i_ready (bus.mem_ready),
        .o_done  (w_mem_done),
        .o_err   (w_mem_err)
    );
`else
    logic w_unused;
    assign w_mem_done = 1'b1;
    assign w_mem_err  = 1'b0;
    assign w_unused   = &{1'b0, bus.mem_ready, w_mem_req, 1'(WAIT_MAX)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
            if (!r_rst_hold) begin
                case (r_state)
                    S_FETCH:  if (w_mem_done) r_state <= S_DECODE;
                    S_DECODE: r_state <= S_EXEC;
                    S_EXEC: begin
                        if (w_jr || is_ctrl_op(bus.opcode)) r_state <= S_FETCH;
                        else if (is_mem_op(bus.opcode))     r_state <= S_MEM;
                        else                                r_state <= S_WB;
                    end
                    S_MEM:    if (w_mem_done) r_state <= w_lw ? S_WB : S_FETCH;
                    S_WB:     r_state <= S_FETCH;
                    default:  r_state <= S_FETCH;
                endcase
            end
        end
    end

    always_comb begin
        bus.pc_wr      = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.alu_sel    = '0;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.pc_src     = PC_PLUS4;
        bus.jal_link   = 1'b0;
        bus.state      = r_state;
        bus.mem_err    = w_mem_err;
        if (w_active) begin
            // ALU/destination selects stay stable from EXEC through write-back.
            if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
                bus.alu_sel = w_rtype ? bus.funct : bus.opcode;
                bus.reg_dst = w_rtype && !w_jr;
                bus.alu_src = !w_rtype && !is_ctrl_op(bus.opcode);
            end
            case (r_state)
                S_FETCH: begin
                    bus.mem_rd = 1'b1;
                    if (w_mem_done) begin
                        bus.ir_wr = 1'b1;
                        bus.pc_wr = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_jr) begin
                        bus.pc_wr  = 1'b1;
                        bus.pc_src = PC_REG;
                    end else if (!w_rtype) begin
                        case (bus.opcode)
                            OP_BEQ: begin bus.pc_wr = bus.zero;  bus.pc_src = PC_BRANCH; end
                            OP_BNE: begin bus.pc_wr = !bus.zero; bus.pc_src = PC_BRANCH; end
                            OP_J:   begin bus.pc_wr = 1'b1;      bus.pc_src = PC_JUMP;   end
                            OP_JAL: begin
                                bus.pc_wr    = 1'b1;
                                bus.pc_src   = PC_JUMP;
                                bus.reg_wr   = 1'b1;
                                bus.jal_link = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    bus.mem_rd = w_lw;
                    bus.mem_wr = (bus.opcode == OP_SW);
                end
                S_WB: begin
                    bus.reg_wr     = 1'b1;
                    bus.mem_to_reg = w_lw;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboarded random bench for multicycle_ctrl; expected per-cycle outputs
// come from an instruction-level model of the controller's behaviour.
module tb_multicycle_ctrl;
    localparam int unsigned WAIT_MAX = 15;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, jal_link, mem_err;
        logic [1:0] pc_src;
        logic [5:0] alu_sel;
        logic       alu_src, reg_dst, mem_to_reg;
    } obs_t;

    typedef struct {
        string tag;
        bit    check;
        logic  rst, ready, zero;
        obs_t  exp, care;
    } cyc_t;

    cyc_t plan[$];
    cyc_t sb[$];
    bit   err_m = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [5:0] ops [0:8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h00, 6'h08};

    function automatic int unsigned acc_len(int unsigned w);
        if (!WAIT_EN) return 1;
        return ((w < WAIT_MAX) ? w : WAIT_MAX) + 1;
    endfunction

    function automatic cyc_t new_cyc(string tag, logic [2:0] st);
        cyc_t c;
        c.tag = tag; c.check = 1'b1; c.rst = 1'b0;
        c.ready = 1'($urandom); c.zero = 1'($urandom);
        c.exp = '0; c.exp.state = st; c.exp.mem_err = err_m;
        c.care = '0; c.care.state = '1;
        c.care.pc_wr = 1'b1; c.care.ir_wr = 1'b1; c.care.mem_rd = 1'b1;
        c.care.mem_wr = 1'b1; c.care.reg_wr = 1'b1; c.care.jal_link = 1'b1;
        c.care.mem_err = 1'b1;
        return c;
    endfunction

    function automatic void push_reset(int unsigned n);
        cyc_t c;
        for (int unsigned k = 0; k < n; k++) begin
            c = new_cyc("reset", 3'd0); c.rst = 1'b1; c.check = 1'b0;
            plan.push_back(c);
        end
        err_m = 1'b0;
        c = new_cyc("post_reset", 3'd0); c.care = '1;
        plan.push_back(c);
    endfunction

    // Instruction-level model: fetch, decode, execute, then memory and
    // write-back only for the instruction classes that need them.
    function automatic void build(string tag, logic [5:0] op, logic [5:0] fn, logic z,
                                  int unsigned wf, int unsigned wm);
        cyc_t c;
        bit jr    = (op == 6'h00) && (fn == 6'h08);
        bit rtype = (op == 6'h00) && !jr;
        bit lw    = (op == 6'h23);
        bit sw    = (op == 6'h2B);
        bit br    = (op == 6'h04) || (op == 6'h05);
        bit jmp   = (op == 6'h02) || (op == 6'h03);
        for (int unsigned k = 0; k < acc_len(wf); k++) begin
            c = new_cyc(tag, 3'd0);
            c.exp.mem_rd = 1'b1;
            if (WAIT_EN) c.ready = (k >= wf);
            if (k == acc_len(wf) - 1) begin
                c.exp.ir_wr = 1'b1; c.exp.pc_wr = 1'b1; c.care.pc_src = '1;
            end
            plan.push_back(c);
        end
        if (WAIT_EN && wf > WAIT_MAX) err_m = 1'b1;
        plan.push_back(new_cyc(tag, 3'd1));
        c = new_cyc(tag, 3'd2);
        c.zero = z;
        if (jr) begin
            c.exp.pc_wr = 1'b1; c.exp.pc_src = 2'd3; c.care.pc_src = '1;
        end else if (br) begin
            c.exp.pc_wr = (op == 6'h04) ? z : !z; c.exp.pc_src = 2'd1; c.care.pc_src = '1;
        end else if (jmp) begin
            c.exp.pc_wr = 1'b1; c.exp.pc_src = 2'd2; c.care.pc_src = '1;
            c.exp.reg_wr = (op == 6'h03); c.exp.jal_link = (op == 6'h03);
        end else begin
            c.care.alu_sel = '1; c.care.alu_src = 1'b1; c.care.reg_dst = !(lw || sw);
            c.exp.alu_sel = rtype ? fn : op; c.exp.alu_src = !rtype; c.exp.reg_dst = rtype;
        end
        plan.push_back(c);
        if (lw || sw) begin
            for (int unsigned k = 0; k < acc_len(wm); k++) begin
                c = new_cyc(tag, 3'd3);
                c.exp.mem_rd = lw; c.exp.mem_wr = sw;
                if (WAIT_EN) c.ready = (k >= wm);
                plan.push_back(c);
            end
            if (WAIT_EN && wm > WAIT_MAX) err_m = 1'b1;
        end
        if (!(jr || br || jmp || sw)) begin
            c = new_cyc(tag, 3'd4);
            c.exp.reg_wr = 1'b1; c.exp.mem_to_reg = lw; c.care.mem_to_reg = 1'b1;
            if (rtype) begin
                c.care.alu_sel = '1; c.care.alu_src = 1'b1; c.care.reg_dst = 1'b1;
                c.exp.alu_sel = fn; c.exp.reg_dst = 1'b1;
            end
            plan.push_back(c);
        end
    endfunction

    task automatic run_plan();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            rst = c.rst;
            bus.mem_ready = c.ready;
            bus.zero = c.zero;
            sb.push_back(c);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(string tag, logic [5:0] op, logic [5:0] fn, logic z,
                         int unsigned wf, int unsigned wm);
        bus.opcode = op;
        bus.funct = fn;
        build(tag, op, fn, z, wf, wm);
        run_plan();
    endtask

    function automatic int unsigned rand_wait();
        if ($urandom_range(0, 7) == 0) return $urandom_range(14, 18);
        return $urandom_range(0, 3);
    endfunction

    initial begin : monitor
        cyc_t c;
        obs_t act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                c = sb.pop_front();
                if (c.check) begin
                    act = {bus.state, bus.pc_wr, bus.ir_wr, bus.mem_rd, bus.mem_wr,
                           bus.reg_wr, bus.jal_link, bus.mem_err, bus.pc_src,
                           bus.alu_sel, bus.alu_src, bus.reg_dst, bus.mem_to_reg};
                    checks++;
                    if (((act ^ c.exp) & c.care) != '0) begin
                        failures++;
                        $display("FAIL %s state%0d: got=%06h expected=%06h care=%06h",
                                 c.tag, c.exp.state, act, c.exp, c.care);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stimulus
        logic [5:0] op, fn;
        int unsigned idx, n;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        push_reset(2);
        run_plan();

        instr("add",      6'h00, 6'h20, 1'($urandom), 0, 0);
        instr("lw_wait2", 6'h23, 6'h11, 1'($urandom), 0, 2);
        instr("beq_z1",   6'h04, 6'h00, 1'b1, 0, 0);
        instr("bne_z1",   6'h05, 6'h00, 1'b1, 0, 0);
        instr("beq_z0",   6'h04, 6'h00, 1'b0, 0, 0);
        instr("bne_z0",   6'h05, 6'h00, 1'b0, 0, 0);
        instr("jal",      6'h03, 6'h15, 1'($urandom), 0, 0);
        instr("jr",       6'h00, 6'h08, 1'($urandom), 0, 0);
        instr("j",        6'h02, 6'h3F, 1'($urandom), 1, 0);
        instr("sw",       6'h2B, 6'h00, 1'($urandom), 0, 1);
        instr("addi",     6'h08, 6'h2A, 1'($urandom), 2, 0);
        instr("lw_stuck", 6'h23, 6'h00, 1'($urandom), 0, 40);
        instr("after_to", 6'h00, 6'h22, 1'($urandom), 0, 0);

        // Abort a load while it is in MEM.
        bus.opcode = 6'h23; bus.funct = 6'h00;
        build("lw_abort", 6'h23, 6'h00, 1'b0, 0, 40);
        while (plan.size() > acc_len(0) + 4) void'(plan.pop_back());
        push_reset(1);
        run_plan();

        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 9);
            op = (idx == 9) ? 6'($urandom) : ops[idx];
            fn = (idx == 7) ? 6'h08 : 6'($urandom);
            bus.opcode = op; bus.funct = fn;
            build("rand", op, fn, 1'($urandom), rand_wait(), rand_wait());
            if (i % 15 == 7) begin
                n = $urandom_range(1, plan.size() - 1);
                while (plan.size() > n) void'(plan.pop_back());
                push_reset(1);
            end
            run_plan();
        end

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got=%0d expected=0 pending", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
